// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS ALU: data width, ALUFun operation codes, shifter op select.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// ALUFun layout: [5:4] selects the class (00 arith, 01 logic, 10 shift, 11 compare).
// Codes that are not listed here produce a zero result.
package alu_pkg;

  // ALUFun codes and the 5-bit shift amount both assume a 32-bit datapath.
  localparam int ALU_W = 32;

  // Arithmetic class
  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;

  // Logic class
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;

  // Shift class
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;

  // Compare class
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  // Barrel shifter operation
  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_op_e;

  // True for the two codes that go through the adder.
  function automatic logic is_arith(input logic [5:0] fun);
    return (fun == ALU_ADD) || (fun == ALU_SUB);
  endfunction

endpackage

// File: rtl/mips_alu_if.sv
// Operand/result bundle between the datapath and the ALU.
// Latency: n/a (wiring only); out is one cycle behind the operands.
// Backpressure: none; a new operation may be presented every cycle.
//
// Signals: in1, in2 (operands), ALUFun (op select), sign (signed/unsigned), out (result).
// When ALU_FLAGS_EN is defined the bundle also carries zero, overflow and negative flags.
// Modports: master = datapath side (drives operands), slave = ALU side (drives result).
interface mips_alu_if;
  import alu_pkg::*;

  logic [ALU_W-1:0] in1;
  logic [ALU_W-1:0] in2;
  logic [5:0]       ALUFun;
  logic             sign;
  logic [ALU_W-1:0] out;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             overflow;
  logic             negative;
`endif

`ifdef ALU_FLAGS_EN
  modport master (output in1, in2, ALUFun, sign, input  out, zero, overflow, negative);
  modport slave  (input  in1, in2, ALUFun, sign, output out, zero, overflow, negative);
`else
  modport master (output in1, in2, ALUFun, sign, input  out);
  modport slave  (input  in1, in2, ALUFun, sign, output out);
`endif

endinterface

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter for SLL / SRL / SRA.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports: op (shift kind), amt (shift amount 0..31), data (value to shift), res (shifted value).
// Left shifts reuse the right-shift stages by bit-reversing the data on the way in and out,
// so only one set of stages exists.
module alu_shifter
  import alu_pkg::*;
(
  input  shift_op_e        op,
  input  logic [4:0]       amt,
  input  logic [ALU_W-1:0] data,
  output logic [ALU_W-1:0] res
);

  function automatic logic [ALU_W-1:0] bit_rev(input logic [ALU_W-1:0] v);
    logic [ALU_W-1:0] r;
    for (int i = 0; i < ALU_W; i++) begin
      r[i] = v[ALU_W-1-i];
    end
    return r;
  endfunction

  logic [ALU_W-1:0] stg [0:5];
  logic             fill;

  // Only an arithmetic right shift drags the sign bit in; the left path always fills with 0.
  assign fill   = (op == SH_SRA) & data[ALU_W-1];
  assign stg[0] = (op == SH_SLL) ? bit_rev(data) : data;

  // Stage k shifts right by 2**k when amt[k] is set.
  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stg[k+1] = amt[k] ? {{SH{fill}}, stg[k][ALU_W-1:SH]} : stg[k];
  end

  assign res = (op == SH_SLL) ? bit_rev(stg[5]) : stg[5];

endmodule

// File: rtl/mips_alu.sv
// 32-bit MIPS ALU: add/sub, bitwise logic, shifts and compares with a registered result.
// Latency: 1 cycle from operands to out (and flags); synchronous active-high reset clears them.
// Backpressure: none; accepts a new operation every cycle, reset discards the pending result.
//
// Ports: clk, reset (sync, active-high), alu (mips_alu_if.slave: in1, in2, ALUFun, sign -> out).
// Optional feature macro ALU_FLAGS_EN: adds registered zero / overflow / negative flags.
// WIDTH must stay 32: the ALUFun encoding and the 5-bit shift amount are tied to it.
module mips_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic    clk,
  input  logic    reset,
  mips_alu_if.slave alu
);

  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [5:0]       fun;
  logic             sgn;

  assign in1 = alu.in1;
  assign in2 = alu.in2;
  assign fun = alu.ALUFun;
  assign sgn = alu.sign;

  // ---------------------------------------------------------------
  // Adder: one carry chain serves both ADD and SUB (in1 + ~in2 + 1).
  // ---------------------------------------------------------------
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] add_res;

  assign is_sub = (fun == ALU_SUB);
  assign b_eff  = is_sub ? ~in2 : in2;

`ifdef ALU_FLAGS_EN
  logic carry;
  assign {carry, add_res} = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
`else
  assign add_res = in1 + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
`endif

  // ---------------------------------------------------------------
  // Shifter: amount comes from in1[4:0], the data from in2.
  // ---------------------------------------------------------------
  shift_op_e        sh_op;
  logic [WIDTH-1:0] sh_res;

  always_comb begin
    sh_op = SH_SRL;
    if (fun == ALU_SLL)      sh_op = SH_SLL;
    else if (fun == ALU_SRA) sh_op = SH_SRA;
  end

  alu_shifter u_shifter (
    .op   (sh_op),
    .amt  (in1[4:0]),
    .data (in2),
    .res  (sh_res)
  );

  // ---------------------------------------------------------------
  // Compare unit. The zero-tests look at in1 as two's complement
  // whatever the sign input says.
  // ---------------------------------------------------------------
  logic eq;
  logic lt;
  logic in1_zero;
  logic in1_neg;

  assign eq       = (in1 == in2);
  assign lt       = sgn ? ($signed(in1) < $signed(in2)) : (in1 < in2);
  assign in1_zero = (in1 == '0);
  assign in1_neg  = in1[WIDTH-1];

  // ---------------------------------------------------------------
  // Result select
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    res_nxt = '0;
    case (fun)
      ALU_ADD, ALU_SUB:          res_nxt = add_res;
      ALU_AND:                   res_nxt = in1 & in2;
      ALU_OR:                    res_nxt = in1 | in2;
      ALU_XOR:                   res_nxt = in1 ^ in2;
      ALU_NOR:                   res_nxt = ~(in1 | in2);
      ALU_A:                     res_nxt = in1;
      ALU_SLL, ALU_SRL, ALU_SRA: res_nxt = sh_res;
      ALU_EQ:                    res_nxt = {{(WIDTH-1){1'b0}}, eq};
      ALU_NEQ:                   res_nxt = {{(WIDTH-1){1'b0}}, ~eq};
      ALU_LT:                    res_nxt = {{(WIDTH-1){1'b0}}, lt};
      ALU_LEZ:                   res_nxt = {{(WIDTH-1){1'b0}}, in1_neg | in1_zero};
      ALU_LTZ:                   res_nxt = {{(WIDTH-1){1'b0}}, in1_neg};
      ALU_GTZ:                   res_nxt = {{(WIDTH-1){1'b0}}, ~in1_neg & ~in1_zero};
      default:                   res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu.out <= '0;
    end else begin
      alu.out <= res_nxt;
    end
  end

`ifdef ALU_FLAGS_EN
  // ---------------------------------------------------------------
  // Flags. Signed overflow: operands (after the SUB inversion) agree
  // in sign but the result does not. Unsigned: carry-out for ADD,
  // borrow (no carry-out) for SUB. The true signed sign of the 33-bit
  // result is the truncated sign bit corrected by the overflow.
  // ---------------------------------------------------------------
  logic s_ovf;
  logic ovf_nxt;
  logic neg_nxt;
  logic arith;

  assign arith = is_arith(fun);
  assign s_ovf = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (add_res[WIDTH-1] != in1[WIDTH-1]);

  always_comb begin
    ovf_nxt = 1'b0;
    neg_nxt = 1'b0;
    if (arith) begin
      if (sgn) begin
        ovf_nxt = s_ovf;
        neg_nxt = add_res[WIDTH-1] ^ s_ovf;
      end else begin
        ovf_nxt = is_sub ? ~carry : carry;
        neg_nxt = add_res[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu.zero     <= 1'b0;
      alu.overflow <= 1'b0;
      alu.negative <= 1'b0;
    end else begin
      alu.zero     <= (res_nxt == '0);
      alu.overflow <= ovf_nxt;
      alu.negative <= neg_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed vectors feed a scoreboard queue,
// a monitor pops one entry per issued operation and compares it one clock later.
module tb_mips_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_alu_if bus ();

  mips_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus)
  );

  typedef struct {
    logic [31:0] out;
    logic        z;
    logic        o;
    logic        n;
    string       name;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // An operation issued before an edge is visible after that edge.
  logic issue_vld = 1'b0;
  logic chk_vld   = 1'b0;
  always @(posedge clk) chk_vld <= issue_vld;

  // Monitor
  always @(posedge clk) begin
    #1;
    if (chk_vld) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: result %h with no expected entry", bus.out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out !== e.out) begin
          n_fail++;
          $display("FAIL %s: out got %h expected %h", e.name, bus.out, e.out);
        end
`ifdef ALU_FLAGS_EN
        n_checks++;
        if ({bus.zero, bus.overflow, bus.negative} !== {e.z, e.o, e.n}) begin
          n_fail++;
          $display("FAIL %s_flags: zof got %b%b%b expected %b%b%b", e.name,
                   bus.zero, bus.overflow, bus.negative, e.z, e.o, e.n);
        end
`endif
      end
    end
  end

  // Present one operation at the falling edge; expected values are hand-computed.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                       input logic s, input logic rst, input logic [31:0] e,
                       input logic o, input logic n, input string nm);
    exp_t x;
    @(negedge clk);
    bus.in1    = a;
    bus.in2    = b;
    bus.ALUFun = f;
    bus.sign   = s;
    reset      = rst;
    issue_vld  = 1'b1;
    x.out  = rst ? 32'h0 : e;
    x.z    = rst ? 1'b0 : (e == 32'h0);
    x.o    = rst ? 1'b0 : o;
    x.n    = rst ? 1'b0 : n;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    issue_vld = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    bus.in1    = '0;
    bus.in2    = '0;
    bus.ALUFun = '0;
    bus.sign   = 1'b0;

    // Reset state (operands present but reset wins)
    issue(32'h1234_5678, 32'h1111_1111, ALU_ADD, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, "reset_state0");
    issue(32'hFFFF_FFFF, 32'h0000_0001, ALU_OR,  1'b0, 1'b1, 32'h0, 1'b0, 1'b0, "reset_state1");

    // Compares
    issue(32'hA8A8_AA55, 32'h9555_6AA5, ALU_LT,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "lt_u_ab");
    issue(32'hA8A8_AA55, 32'h9555_6AA5, ALU_LT,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "lt_s_ab");
    issue(32'h9555_6AA5, 32'hA8A8_AA55, ALU_LT,  1'b1, 1'b0, 32'h1, 1'b0, 1'b0, "lt_s_ba");
    issue(32'h9555_6AA5, 32'hA8A8_AA55, ALU_LT,  1'b0, 1'b0, 32'h1, 1'b0, 1'b0, "lt_u_ba");
    issue(32'hFFFF_FFFF, 32'h0000_0001, ALU_LT,  1'b1, 1'b0, 32'h1, 1'b0, 1'b0, "lt_s_neg");
    issue(32'hFFFF_FFFF, 32'h0000_0001, ALU_LT,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "lt_u_big");
    issue(32'hA8A8_AA55, 32'hA8A8_AA55, ALU_EQ,  1'b0, 1'b0, 32'h1, 1'b0, 1'b0, "eq");
    issue(32'hA8A8_AA55, 32'hA8A8_AA55, ALU_NEQ, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "neq");
    issue(32'h0000_0000, 32'h0000_0000, ALU_LEZ, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, "lez_zero");
    issue(32'h8000_0000, 32'h0000_0000, ALU_LTZ, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, "ltz_min");
    issue(32'h8000_0000, 32'h0000_0000, ALU_GTZ, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "gtz_min");
    issue(32'h0000_0001, 32'h0000_0000, ALU_GTZ, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, "gtz_one");

    // Shifts
    issue(32'd8,  32'hF101_0101, ALU_SRA, 1'b0, 1'b0, 32'hFFF1_0101, 1'b0, 1'b0, "sra8");
    issue(32'd12, 32'hF101_0101, ALU_SRA, 1'b0, 1'b0, 32'hFFFF_1010, 1'b0, 1'b0, "sra12");
    issue(32'd14, 32'hF101_0101, ALU_SRA, 1'b0, 1'b0, 32'hFFFF_C404, 1'b0, 1'b0, "sra14");
    issue(32'd15, 32'hF101_0101, ALU_SRA, 1'b0, 1'b0, 32'hFFFF_E202, 1'b0, 1'b0, "sra15");
    issue(32'd8,  32'hF101_0101, ALU_SRL, 1'b0, 1'b0, 32'h00F1_0101, 1'b0, 1'b0, "srl8");
    issue(32'h25, 32'h0000_0001, ALU_SLL, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b0, "sll5_upper_ignored");
    issue(32'h0,  32'h8765_4321, ALU_SRA, 1'b0, 1'b0, 32'h8765_4321, 1'b0, 1'b0, "sra0_pass");
    issue(32'd31, 32'h8000_0000, ALU_SRL, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, "srl31");

    // Arithmetic
    issue(32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_carry");
    issue(32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b0, "add_sovf");
    issue(32'h0000_0005, 32'h0000_0007, ALU_SUB, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, "sub_s_neg");
    issue(32'h0000_0005, 32'h0000_0007, ALU_SUB, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1, "sub_u_borrow");
    issue(32'h0000_0009, 32'h0000_0004, ALU_SUB, 1'b0, 1'b0, 32'h0000_0005, 1'b0, 1'b0, "sub_u_plain");

    // Reset mid-stream discards the pending result; recovery one cycle later
    issue(32'h0000_0001, 32'h0000_0002, ALU_ADD, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, "reset_mid");
    issue(32'h0000_0003, 32'h0000_0004, ALU_ADD, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, "after_reset");

    // Logic and undefined code
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 1'b0, 1'b0, 32'hF000_F000, 1'b0, 1'b0, "and");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR,  1'b0, 1'b0, 32'hFFF0_FFF0, 1'b0, 1'b0, "or");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_XOR, 1'b0, 1'b0, 32'h0FF0_0FF0, 1'b0, 1'b0, "xor");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_NOR, 1'b0, 1'b0, 32'h000F_000F, 1'b0, 1'b0, "nor");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_A,   1'b0, 1'b0, 32'hF0F0_F0F0, 1'b0, 1'b0, "pass_a");
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 6'b000010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "undef_code");

    idle();

    // Drain: every issued operation must have been checked within a few cycles.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
